packet_tx: RTL and testbench
============================

Name: packet_tx

Overview:
- Response framer for the UART ALU. It sits between the ALU/echo result path and the UART transmitter.
- Accepts one result (opcode, payload word, payload byte count) over a valid/ready handshake.
- Serialises it into a byte-stream frame using the same format the host sends: opcode, reserved, length LSB, length MSB, then payload bytes least-significant first.
- Downstream is the UART TX byte interface (valid/ready).

Parameters:
- MAX_BYTES, 8: maximum payload bytes per frame; sets data_i width to 8*MAX_BYTES.
- RESV_BYTE, 8'h00: constant value emitted in the reserved header slot.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- opcode_i  input  8  opcode echoed in frame header; passed through unchecked
- data_i  input  8*MAX_BYTES  payload word, byte 0 = bits [7:0]
- len_i  input  8  payload byte count requested
- valid_i  input  1  request valid (from ALU/echo path)
- ready_o  output  1  block can accept a request
- data_o  output  8  byte to UART TX
- valid_o  output  1  data_o valid
- ready_i  input  1  UART TX accepts byte
- busy_o  output  1  frame in progress
- state_o  output  3  debug state encoding

Behaviour:
- Reset (rst_n low, takes effect immediately): state IDLE; valid_o=0, data_o=0, busy_o=0, state_o=0; all captured registers and the payload index are cleared.
- ready_o = (state==IDLE). valid_i is ignored while rst_n is low.
- States and state_o encoding: IDLE=0, OPCODE=1, RESV=2, LEN_LSB=3, LEN_MSB=4, PAYLOAD=5.
- IDLE:
  - On valid_i&&ready_o, register opcode_i and data_i.
  - Register len = min(len_i, MAX_BYTES).
  - Go to OPCODE; valid_o rises the next cycle.
- Frame length field = 4 + len (+1 with checksum), 16 bits. It is split into LEN_LSB (bits [7:0]) and LEN_MSB (bits [15:8]).
- In every non-IDLE state: valid_o=1, busy_o=1.
  - data_o is selected from state and the captured registers.
  - data_o stays constant while valid_o&&!ready_i.
- A byte is transferred only on valid_o&&ready_i. Each transfer advances the state:
  - OPCODE -> RESV -> LEN_LSB -> LEN_MSB.
  - LEN_MSB -> PAYLOAD if len>0, else -> IDLE.
- PAYLOAD:
  - data_o = captured byte[idx]; idx starts at 0.
  - Each transfer increments idx.
  - After the transfer with idx==len-1, go to IDLE and clear idx.
- Throughput: one byte per cycle while ready_i=1. A frame occupies 4+len cycles, plus one IDLE bubble before the next request can be accepted.
- len_i > MAX_BYTES is clamped to MAX_BYTES. len_i==0 sends a 4-byte header-only frame.
- Reset asserted mid-frame aborts the frame: valid_o drops asynchronously and no partial tail is emitted after release.
- valid_i held high during a frame has no effect; it is accepted on the first IDLE cycle.

Optional Feature:
- Macro: PACKET_TX_CHECKSUM_EN.
- When defined:
  - A CHKSUM state (state_o=6) follows the last payload byte, or LEN_MSB if len==0.
  - It emits the XOR of every preceding byte of the frame.
  - The length field includes this byte (5+len).
  - The XOR accumulator clears in IDLE and updates on each transfer.
- When undefined: no CHKSUM state, length field = 4+len, no accumulator logic.

Test Plan:
- opcode 8'hA5, len 4, data 64'hDEADBEEF, ready_i=1 -> data_o A5,00,08,00,EF,BE,AD,DE on 8 consecutive valid cycles; ready_o=1 on the next cycle.
- Same request with ready_i toggling 1,0,0,1,... -> data_o and valid_o held stable across every stall; the byte order is unchanged and exactly 8 transfers occur.
- opcode 8'h3C, len 0 -> 3C,00,04,00 then IDLE; no payload byte emitted.
- len_i=12, data 64'h0807060504030201 -> length field 0C,00, then payload 01..08 (8 bytes only).
- rst_n pulsed low during PAYLOAD idx 2 -> valid_o=0 immediately; after release ready_o=1, and the next request's first byte is its opcode.
- With PACKET_TX_CHECKSUM_EN: opcode 8'h01, len 1, data 8'h5A -> 01,00,06,00,5A,5D.

Source files
------------

// File: rtl/packet_tx.sv
// Response framer: serialises {opcode, reserved, length LSB/MSB, payload LSB-first} onto a byte stream.
// Define PACKET_TX_CHECKSUM_EN to append a trailing XOR checksum byte (state 6).
module packet_tx #(
  parameter int         MAX_BYTES = 8,
  parameter logic [7:0] RESV_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             opcode_i,
  input  logic [8*MAX_BYTES-1:0] data_i,
  input  logic [7:0]             len_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic [2:0]             state_o
);

  // Handshakes: a word/byte moves on a rising clk edge where valid and ready are
  // both high; the source holds its valid and data stable until that happens.

  localparam int         IW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);
`ifdef PACKET_TX_CHECKSUM_EN
  localparam logic [15:0] HDR_LEN = 16'd5;
`else
  localparam logic [15:0] HDR_LEN = 16'd4;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPCODE  = 3'd1,
    RESV    = 3'd2,
    LEN_LSB = 3'd3,
    LEN_MSB = 3'd4,
    PAYLOAD = 3'd5,
    CHKSUM  = 3'd6
  } state_t;

  state_t                 state_q;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [7:0]             len_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_d;
  logic [7:0]             dout_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   xfer;
  logic                   last;
  logic [15:0]            frame_len;
`ifdef PACKET_TX_CHECKSUM_EN
  logic [7:0]             chk_q;
  logic [7:0]             chk_d;
  assign chk_d = chk_q ^ dout_q;
`endif

  assign xfer      = valid_q && ready_i;
  assign idx_d     = idx_q + 1'b1;
  assign last      = ({{(8-IW){1'b0}}, idx_q} == (len_q - 8'd1));
  assign frame_len = HDR_LEN + {8'd0, len_q};

  assign ready_o = (state_q == IDLE);
  assign data_o  = dout_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= 8'd0;
      idx_q   <= '0;
      dout_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PACKET_TX_CHECKSUM_EN
      chk_q   <= 8'd0;
`endif
    end else begin
`ifdef PACKET_TX_CHECKSUM_EN
      if (xfer) chk_q <= chk_d;
`endif
      case (state_q)
        IDLE: begin
          dout_q  <= 8'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
`ifdef PACKET_TX_CHECKSUM_EN
          chk_q   <= 8'd0;
`endif
          if (valid_i) begin
            data_q  <= data_i;
            len_q   <= (len_i > MAX_LEN) ? MAX_LEN : len_i;
            dout_q  <= opcode_i;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= OPCODE;
          end
        end
        OPCODE: if (xfer) begin
          dout_q  <= RESV_BYTE;
          state_q <= RESV;
        end
        RESV: if (xfer) begin
          dout_q  <= frame_len[7:0];
          state_q <= LEN_LSB;
        end
        LEN_LSB: if (xfer) begin
          dout_q  <= frame_len[15:8];
          state_q <= LEN_MSB;
        end
        LEN_MSB: if (xfer) begin
          if (len_q != 8'd0) begin
            dout_q  <= data_q[7:0];
            state_q <= PAYLOAD;
          end else begin
`ifdef PACKET_TX_CHECKSUM_EN
            dout_q  <= chk_d;
            state_q <= CHKSUM;
`else
            dout_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end
        end
        PAYLOAD: if (xfer) begin
          if (last) begin
            idx_q <= '0;
`ifdef PACKET_TX_CHECKSUM_EN
            dout_q  <= chk_d;
            state_q <= CHKSUM;
`else
            dout_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end else begin
            idx_q  <= idx_d;
            dout_q <= data_q[{idx_d, 3'b000} +: 8];
          end
        end
`ifdef PACKET_TX_CHECKSUM_EN
        CHKSUM: if (xfer) begin
          dout_q  <= 8'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`endif
        default: begin
          dout_q  <= 8'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_tx.sv
// Bench for packet_tx: directed vector table, reset-abort sequence, and random frames
// scored against a frame-building reference model.
module tb_packet_tx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  opcode_i;
  logic [63:0] data_i;
  logic [7:0]  len_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic [2:0]  state_o;

  packet_tx #(.MAX_BYTES(8), .RESV_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i), .data_i(data_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  op;
    logic [63:0] d;
    logic [7:0]  l;
    int          mode;     // 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready
    logic [15:0] exp_len;  // frame length field without checksum
  } vec_t;
  vec_t vecs[5];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: builds the byte sequence of a whole frame from the frame rules.
  task automatic build_frame(input logic [7:0] op, input logic [63:0] d, input logic [7:0] l);
    int k;
    logic [15:0] flen;
    logic [7:0] x;
    k = (l > 8) ? 8 : int'(l);
    flen = 16'(4 + k);
`ifdef PACKET_TX_CHECKSUM_EN
    flen = flen + 16'd1;
`endif
    exp_q.delete();
    exp_q.push_back(op);
    exp_q.push_back(8'h00);
    exp_q.push_back(flen[7:0]);
    exp_q.push_back(flen[15:8]);
    for (int i = 0; i < k; i++) exp_q.push_back(d[8*i +: 8]);
`ifdef PACKET_TX_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  // driver: issue one request, then drain the frame under the chosen ready pattern
  task automatic run_frame(input logic [7:0] op, input logic [63:0] d, input logic [7:0] l,
                           input int mode, input bit chk_len, input logic [15:0] exp_len);
    int w, n, cyc, total;
    bit stall, rdy;
    logic [7:0] prev, e;
    build_frame(op, d, l);
    total = exp_q.size();
    w = 0;
    while (!ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check(ready_o == 1'b1, "ready_wait", ready_o, 1);
    opcode_i = op; data_i = d; len_i = l; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    check(busy_o == 1'b1 && ready_o == 1'b0, "busy_start", {busy_o, ready_o}, 2'b10);
    n = 0; cyc = 0; stall = 1'b0; prev = 8'h00;
    while (n < total && cyc < 300) begin
      if (stall) check(valid_o == 1'b1 && data_o == prev, "stall_hold", {valid_o, data_o}, {1'b1, prev});
      check(valid_o == 1'b1, "valid_hi", valid_o, 1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      ready_i = rdy;
      if (valid_o && rdy) begin
        e = exp_q.pop_front();
        check(data_o == e, "byte", data_o, e);
        if (chk_len && n == 2) check(data_o == exp_len[7:0], "len_lsb", data_o, exp_len[7:0]);
        if (chk_len && n == 3) check(data_o == exp_len[15:8], "len_msb", data_o, exp_len[15:8]);
        n++;
      end
      stall = valid_o && !rdy;
      prev = data_o;
      @(negedge clk);
      cyc++;
    end
    ready_i = 1'b0;
    check(n == total, "frame_timeout", n, total);
    check(ready_o == 1'b1 && valid_o == 1'b0 && busy_o == 1'b0, "idle_after",
          {ready_o, valid_o, busy_o}, 3'b100);
  endtask

  initial begin
    vecs[0] = '{op: 8'hA5, d: 64'hDEADBEEF,         l: 8'd4,  mode: 0, exp_len: 16'd8};
    vecs[1] = '{op: 8'hA5, d: 64'hDEADBEEF,         l: 8'd4,  mode: 1, exp_len: 16'd8};
    vecs[2] = '{op: 8'h3C, d: 64'h0,                l: 8'd0,  mode: 0, exp_len: 16'd4};
    vecs[3] = '{op: 8'h55, d: 64'h0807060504030201, l: 8'd12, mode: 0, exp_len: 16'd12};
    vecs[4] = '{op: 8'h01, d: 64'h5A,               l: 8'd1,  mode: 0, exp_len: 16'd5};

    rst_n = 1'b0; opcode_i = 8'h00; data_i = 64'h0; len_i = 8'h00; valid_i = 1'b1; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check(state_o == 3'd0 && valid_o == 1'b0 && busy_o == 1'b0, "reset_state",
          {state_o, valid_o, busy_o}, 5'b0);
    check(data_o == 8'h00, "reset_data", data_o, 0);
    check(ready_o == 1'b1, "reset_ready", ready_o, 1);
    valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check(state_o == 3'd0, "idle_no_req", state_o, 0);

    for (int i = 0; i < 5; i++) begin
      logic [15:0] el;
      el = vecs[i].exp_len;
`ifdef PACKET_TX_CHECKSUM_EN
      el = el + 16'd1;
`endif
      run_frame(vecs[i].op, vecs[i].d, vecs[i].l, vecs[i].mode, 1'b1, el);
    end

    // reset asserted while payload byte idx 2 is presented
    opcode_i = 8'h77; data_i = 64'h1122334455667788; len_i = 8'd4; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (6) @(negedge clk);
    check(data_o == 8'h66 && state_o == 3'd5, "pre_abort", {state_o, data_o}, {3'd5, 8'h66});
    rst_n = 1'b0;
    #1;
    check(valid_o == 1'b0 && busy_o == 1'b0 && state_o == 3'd0, "abort_async",
          {valid_o, busy_o, state_o}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b0;
    @(negedge clk);
    check(ready_o == 1'b1 && valid_o == 1'b0, "abort_no_tail", {ready_o, valid_o}, 2'b10);
    run_frame(8'h9E, 64'hCAFE, 8'd2, 0, 1'b0, 16'd0);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] rd;
      rd = {$urandom(), $urandom()};
      run_frame(8'($urandom_range(0, 255)), rd, 8'($urandom_range(0, 12)), 2, 1'b0, 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
